// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive ingress stage.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/eth_rx_ingress_crc32_d8.sv
// Combinational byte-wide reflected CRC-32 update (LSB-first, no final XOR).
module eth_crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'd0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_ingress.sv
// GMII receive ingress: strips preamble/SFD, writes DA..FCS into the byte FIFO,
// reports per-frame status. FCS checking is built only when RX_FCS_CHECK_EN is defined.
module eth_rx_ingress
  import eth_rx_pkg::*;
#(
  parameter int LEN_W   = 11,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int MIN_PRE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  input  logic             fifo_full,
  output logic             fifo_write,
  output logic [7:0]       fifo_data,
  output logic             frame_done,
  output logic             frame_err,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_fcs_bad,
  output logic [15:0]      drop_cnt
);

  rx_state_t        state, state_d;
  logic [3:0]       pre_cnt;
  logic [LEN_W-1:0] len;
  logic             wr_q;
  logic             ovf_q;

  logic             ovf_now;
  logic             accept;
  logic             pre_load;
  logic             pre_inc;
  logic             start_data;
  logic             done_d;
  logic             err_d;
  logic             fcs_bad_d;
  logic             fcs_mismatch;

  assign fifo_write = wr_q & ~fifo_full;

`ifdef RX_FCS_CHECK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_next;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii_rxd),
    .crc_out (crc_next)
  );

  assign fcs_mismatch = (crc_q != CRC32_RESIDUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC32_INIT;
    end else if (start_data) begin
      crc_q <= CRC32_INIT;
    end else if (accept) begin
      crc_q <= crc_next;
    end
  end
`else
  assign fcs_mismatch = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    ovf_now    = wr_q & fifo_full;
    accept     = 1'b0;
    pre_load   = 1'b0;
    pre_inc    = 1'b0;
    start_data = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fcs_bad_d  = 1'b0;
    case (state)
      IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE_BYTE) begin
            state_d  = PRE;
            pre_load = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else if (gmii_rx_er) begin
          state_d = DROP;
        end else if (gmii_rxd == PREAMBLE_BYTE) begin
          pre_inc = 1'b1;
        end else if (gmii_rxd == SFD_BYTE && {28'd0, pre_cnt} >= 32'(MIN_PRE)) begin
          state_d    = DATA;
          start_data = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        // An overflow on the final edge still has to be reported in this frame's status.
        if (!gmii_rx_dv) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          fcs_bad_d = fcs_mismatch;
          err_d     = (len < LEN_W'(MIN_LEN)) | ovf_now | ovf_q | fcs_mismatch;
        end else if (ovf_now || gmii_rx_er || len == LEN_W'(MAX_LEN)) begin
          state_d = DROP;
        end else begin
          accept = 1'b1;
        end
      end
      DROP: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pre_cnt       <= '0;
      len           <= '0;
      wr_q          <= 1'b0;
      fifo_data     <= '0;
      ovf_q         <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      frame_len     <= '0;
      frame_fcs_bad <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      state      <= state_d;
      frame_done <= done_d;
      wr_q       <= accept;
      if (accept) begin
        fifo_data <= gmii_rxd;
      end
      if (pre_load) begin
        pre_cnt <= 4'd1;
      end else if (pre_inc && pre_cnt != 4'd15) begin
        pre_cnt <= pre_cnt + 4'd1;
      end
      if (state == IDLE || start_data) begin
        len <= '0;
      end else if (accept) begin
        len <= len + 1'b1;
      end
      if (start_data) begin
        ovf_q <= 1'b0;
      end else if (ovf_now) begin
        ovf_q <= 1'b1;
      end
      if (done_d) begin
        frame_len     <= len;
        frame_err     <= err_d;
        frame_fcs_bad <= fcs_bad_d;
        if (err_d && drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_ingress.sv
// Directed, table-driven bench for eth_rx_ingress; FCS cases build with RX_FCS_CHECK_EN.
module tb_eth_rx_ingress;
  import eth_rx_pkg::*;

`ifdef RX_FCS_CHECK_EN
  localparam int TB_MIN_LEN = 4;
`else
  localparam int TB_MIN_LEN = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic        fifo_full;
  logic        fifo_write;
  logic [7:0]  fifo_data;
  logic        frame_done;
  logic        frame_err;
  logic [10:0] frame_len;
  logic        frame_fcs_bad;
  logic [15:0] drop_cnt;

  eth_rx_ingress #(
    .LEN_W   (11),
    .MIN_LEN (TB_MIN_LEN),
    .MAX_LEN (1518),
    .MIN_PRE (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .gmii_rxd      (gmii_rxd),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rx_er    (gmii_rx_er),
    .fifo_full     (fifo_full),
    .fifo_write    (fifo_write),
    .fifo_data     (fifo_data),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .frame_len     (frame_len),
    .frame_fcs_bad (frame_fcs_bad),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive FIFO-side monitor, sampled mid-cycle.
  logic [7:0]  wr_log[$];
  int          wr_cyc[$];
  int          done_total = 0;
  logic [10:0] last_len;
  logic        last_err;
  logic        last_fcs;
  int          last_done_cyc;
  logic        prev_done = 1'b0;
  logic        consec = 1'b0;

  always @(negedge clk) begin
    if (fifo_write === 1'b1) begin
      wr_log.push_back(fifo_data);
      wr_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      done_total    <= done_total + 1;
      last_len      <= frame_len;
      last_err      <= frame_err;
      last_fcs      <= frame_fcs_bad;
      last_done_cyc <= cyc;
      if (prev_done) consec <= 1'b1;
    end
    prev_done <= (frame_done === 1'b1);
  end

  int vec_n  = 0;
  int miss_n = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pay[0:2047];

  task automatic fill_pattern();
    for (int i = 0; i < 2048; i++) pay[i] = 8'(i);
  endtask

`ifdef RX_FCS_CHECK_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction
`endif

  // full_at=F raises fifo_full during the cycle in which data byte F sits in the write register.
  task automatic send_frame(input int n_pre, input bit sfd, input int n_data, input int er_at,
                            input int full_at, output int first_cyc, output int low_cyc);
    first_cyc = -1;
    for (int i = 0; i < n_pre; i++) begin
      tick();
      gmii_rx_dv = 1'b1; gmii_rxd = 8'h55; gmii_rx_er = 1'b0; fifo_full = 1'b0;
    end
    if (sfd) begin
      tick();
      gmii_rx_dv = 1'b1; gmii_rxd = 8'hD5; gmii_rx_er = 1'b0; fifo_full = 1'b0;
    end
    for (int k = 1; k <= n_data; k++) begin
      tick();
      gmii_rx_dv = 1'b1;
      gmii_rxd   = pay[k-1];
      gmii_rx_er = (k == er_at);
      fifo_full  = (full_at != 0) && (k == full_at + 1);
      if (k == 1) first_cyc = cyc;
    end
    tick();
    gmii_rx_dv = 1'b0; gmii_rxd = 8'h00; gmii_rx_er = 1'b0;
    fifo_full  = (full_at != 0) && (n_data == full_at);
    low_cyc    = cyc;
    repeat (4) begin
      tick();
      fifo_full = 1'b0;
    end
  endtask

  typedef struct {
    string name;
    int    n_pre;
    bit    sfd;
    int    n_data;
    int    er_at;
    int    full_at;
    int    exp_wr;
    int    exp_len;
    bit    exp_done;
    bit    data_end;
  } vec_t;

  localparam int NV = 10;
  vec_t tv[NV];

  int exp_drop = 0;

  task automatic check_status(input string nm, input int d0, input int low_cyc, input int exp_len,
                              input bit exp_err, input bit exp_fcs);
    check({nm, "_done"}, 32'(done_total - d0), 32'd1);
    check({nm, "_donecyc"}, 32'(last_done_cyc), 32'(low_cyc + 1));
    check({nm, "_len"}, 32'(last_len), 32'(exp_len));
    check({nm, "_err"}, 32'(last_err), 32'(exp_err));
    check({nm, "_fcs"}, 32'(last_fcs), 32'(exp_fcs));
    if (exp_err) exp_drop++;
    check({nm, "_dropcnt"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  initial begin
    int   wr0, d0, nwr, first_cyc, low_cyc;
    bit   ok, exp_err, exp_fcs;
    vec_t v;

    tv[0] = '{"good",      7, 1, 64,   0, 0,  64,   64,   1, 1};
    tv[1] = '{"runt",      7, 1, 20,   0, 0,  20,   20,   1, 1};
    tv[2] = '{"min_m1",    7, 1, 63,   0, 0,  63,   63,   1, 1};
    tv[3] = '{"overflow",  7, 1, 64,   0, 10, 9,    10,   1, 0};
    tv[4] = '{"short_pre", 1, 1, 10,   0, 0,  0,    0,    1, 0};
    tv[5] = '{"rx_er",     7, 1, 64,   5, 0,  4,    4,    1, 0};
    tv[6] = '{"pre_abort", 3, 0, 0,    0, 0,  0,    0,    0, 0};
    tv[7] = '{"max_len",   7, 1, 1518, 0, 0,  1518, 1518, 1, 1};
    tv[8] = '{"too_long",  7, 1, 1520, 0, 0,  1518, 1518, 1, 0};
    tv[9] = '{"min_pre",   2, 1, 64,   0, 0,  64,   64,   1, 1};

    rst = 1'b1; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; fifo_full = 1'b0;
    tick();
    tick();
    check("rst_fifo_write", 32'(fifo_write), 32'd0);
    check("rst_fifo_data", 32'(fifo_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_fcs_bad", 32'(frame_fcs_bad), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    for (int t = 0; t < NV; t++) begin
      v = tv[t];
      fill_pattern();
      wr0 = wr_log.size();
      d0  = done_total;
      send_frame(v.n_pre, v.sfd, v.n_data, v.er_at, v.full_at, first_cyc, low_cyc);
      nwr = wr_log.size() - wr0;
      check({v.name, "_writes"}, 32'(nwr), 32'(v.exp_wr));
      ok = (nwr == v.exp_wr);
      if (ok) begin
        for (int j = 0; j < v.exp_wr; j++) if (wr_log[wr0+j] !== pay[j]) ok = 1'b0;
      end
      check({v.name, "_data"}, 32'(ok), 32'd1);
      if (v.exp_wr > 0 && nwr > 0) check({v.name, "_latency"}, 32'(wr_cyc[wr0]), 32'(first_cyc + 1));
      if (v.exp_done) begin
        exp_fcs = 1'b0;
`ifdef RX_FCS_CHECK_EN
        if (v.data_end) begin
          logic [31:0] c;
          c = 32'hFFFFFFFF;
          for (int j = 0; j < v.exp_len; j++) c = crc_upd(c, pay[j]);
          exp_fcs = (c != 32'hDEBB20E3);
        end
`endif
        exp_err = v.data_end ? ((v.exp_len < TB_MIN_LEN) || exp_fcs) : 1'b1;
        check_status(v.name, d0, low_cyc, v.exp_len, exp_err, exp_fcs);
      end else begin
        check({v.name, "_nodone"}, 32'(done_total - d0), 32'd0);
      end
    end

    // Reset pulse on data byte 30 of 100; the tail of the frame must come out as one dropped frame.
    fill_pattern();
    wr0 = wr_log.size();
    d0  = done_total;
    for (int i = 0; i < 7; i++) begin
      tick();
      gmii_rx_dv = 1'b1; gmii_rxd = 8'h55;
    end
    tick();
    gmii_rxd = 8'hD5;
    for (int k = 1; k <= 100; k++) begin
      tick();
      gmii_rxd = pay[k-1];
      rst      = (k == 30);
      if (k == 31) check("rstmid_drop_cnt", 32'(drop_cnt), 32'd0);
    end
    check("rstmid_writes", 32'(wr_log.size() - wr0), 32'd29);
    check("rstmid_nodone", 32'(done_total - d0), 32'd0);
    tick();
    gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
    low_cyc = cyc;
    repeat (4) tick();
    check("rstmid_writes_after", 32'(wr_log.size() - wr0), 32'd29);
    exp_drop = 0;
    check_status("rstmid", d0, low_cyc, 0, 1'b1, 1'b0);

`ifdef RX_FCS_CHECK_EN
    begin
      logic [7:0] fcs_vec[13];
      fcs_vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
      for (int j = 0; j < 13; j++) pay[j] = fcs_vec[j];
      d0 = done_total;
      send_frame(7, 1, 13, 0, 0, first_cyc, low_cyc);
      check_status("fcs_good", d0, low_cyc, 13, 1'b0, 1'b0);
      pay[12] = 8'hCA;
      d0 = done_total;
      send_frame(7, 1, 13, 0, 0, first_cyc, low_cyc);
      check_status("fcs_bad", d0, low_cyc, 13, 1'b1, 1'b1);
    end
`endif

    check("no_back_to_back_done", 32'(consec), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
